osc_count_capture: RTL
======================

Name: osc_count_capture

Overview:
Receiving end of the sample-control sequence: consumes OscSel/Count/Sample/Resetn strobes and the raw ring-oscillator outputs of the aging sensors.
- Counts rising edges of the selected oscillator while Count_i is high.
- On Sample_i, pushes a tagged result into a small FIFO.
- A ready/valid port drains the FIFO toward the readout SRAM writer.
- Sits between the oscillator array and the readout network.

Parameters:
NumOsc, 10, number of oscillator inputs; must be ≤ 32.
CntW, 16, edge counter width; the counter saturates at its maximum value.
FifoDepth, 4, result FIFO entries; power of 2, ≥ 2.

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
OscIn_i  in  NumOsc  raw oscillator outputs; asynchronous to clk, frequency < clk/2
OscSel_i  in  5  oscillator index under test
Count_i  in  1  counting window enable
Sample_i  in  1  one-cycle capture strobe
Resetn_i  in  1  synchronous active-low counter clear
rd_valid_o  out  1  FIFO head valid
rd_ready_i  in  1  consumer ready; pop when valid && ready
rd_data_o  out  CntW+5  {OscSel[4:0], count[CntW-1:0]} at FIFO head
drop_cnt_o  out  8  saturating count of results dropped on a full FIFO
busy_o  out  1  high while Count_i is high or the FIFO is non-empty

Behaviour:
Reset (rstn low): counter = 0, FIFO empty, rd_valid_o = 0, rd_data_o = 0, drop_cnt_o = 0, busy_o = 0, synchronizer flops = 0.

Oscillator path:
- Mux selects OscIn_i[OscSel_i]. If OscSel_i ≥ NumOsc, the mux outputs constant 0.
- Mux output passes through a 2-FF synchronizer, then a registered rising-edge detect.
- An oscillator edge reaches the detect pulse 3 clk later.
- Changing OscSel_i may produce one spurious edge; the upstream controller changes OscSel only while Count_i is low.

Counter, with priority in this order:
1. Resetn_i low: counter <= 0 on the next edge.
2. Else Count_i high and edge pulse: counter + 1, holding at 2^CntW-1 (saturate, no wrap).
3. Else the counter holds.
- Count_i gates at detect time. Edges still in the synchronizer when Count_i falls are not counted.

Capture:
- On a Sample_i cycle, push {OscSel_i, counter register value at that cycle}.
- The push does not include an increment occurring in the same cycle.
- Sample_i together with Resetn_i low: the pre-clear value is pushed, then the counter clears.
- Sample_i held high for N cycles produces N pushes.

FIFO:
- Storage is registers; rd_data_o is driven directly from the head entry (first-word fall-through).
- rd_valid_o rises 1 cycle after the push into an empty FIFO.
- A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Otherwise the result is dropped and drop_cnt_o increments, saturating at 255.
- Simultaneous push and pop on an empty FIFO: there is no pop (valid was 0), so the push is accepted.
- Pointers are log2(FifoDepth)+1 bits wide; full/empty comes from the MSB compare.
- rd_data_o is held stable while rd_valid_o is high and rd_ready_i is low.

drop_cnt_o is cleared only by rstn.

Mid-operation rstn assertion clears everything immediately (asynchronous). Entries in flight are lost; no partial output appears.

Decomposition:
Package osc_capture_pkg:
- OSC_SEL_W = 5
- DROP_W = 8
- Result field offsets: SEL_LSB = CntW, CNT_LSB = 0
- Function clog2 for FIFO pointers

Sub-module osc_edge_sync: 2-FF synchronizer plus rising-edge register, 1-bit in, 1-bit pulse out. It is reused by other sensor readout blocks. The FIFO stays inline.

Test Plan:
1. Osc 3 driven with period 10 clk; OscSel=3; Count_i high for 100 cycles; Sample_i pulse 5 cycles later -> rd_data = {5'd3, 16'd10} (±1 per phase, bench checks the phase-aligned value 10); drop_cnt = 0.
2. OscSel=12 with NumOsc=10, osc toggling, Count_i high for 200 cycles, then Sample -> count field 0.
3. CntW=4; 40 edges inside the window; Sample -> count = 15 (saturated).
4. Sample_i and Resetn_i low in the same cycle with counter = 7 -> pushed value 7; the next Sample with no counting pushes 0.
5. rd_ready_i = 0; 6 Sample pulses with FifoDepth=4 -> 4 entries retained, drop_cnt = 2. Then rd_ready_i = 1 -> 4 entries pop in push order, rd_valid_o falls after the 4th.
6. FIFO full, Sample_i and pop in the same cycle -> push accepted, drop_cnt unchanged. Then rstn pulsed mid-window -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/osc_count_capture_pkg.sv
// osc_count_capture shared constants.
// Result layout and FIFO pointer helper.
package osc_capture_pkg;

  localparam int OSC_SEL_W = 5;
  localparam int DROP_W    = 8;

  // Default counter width; the top derives
  // its own offsets from its CntW parameter.
  localparam int CNT_W   = 16;
  localparam int SEL_LSB = CNT_W;
  localparam int CNT_LSB = 0;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/osc_count_capture_if.sv
// Result drain port of osc_count_capture.
// valid/ready, pop on valid && ready.
interface osc_count_capture_if #(
  parameter int DW = 21
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/osc_edge_sync.sv
// 2-FF synchronizer plus registered rising
// edge detect; input edge -> pulse in 3 clk.
module osc_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       pulse_q;

  // resynchronise, remember last level, flag 0->1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], d_i};
      prev_q  <= sync_q[1];
      pulse_q <= sync_q[1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/osc_count_capture.sv
// Counts selected ring-oscillator edges and
// queues tagged samples for the readout path.
module osc_count_capture
  import osc_capture_pkg::*;
#(
  parameter int NumOsc    = 10,
  parameter int CntW      = 16,
  parameter int FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NumOsc-1:0]    OscIn_i,
  input  logic [OSC_SEL_W-1:0] OscSel_i,
  input  logic                 Count_i,
  input  logic                 Sample_i,
  input  logic                 Resetn_i,
  osc_count_capture_if.master  rd,
  output logic [DROP_W-1:0]    drop_cnt_o,
  output logic                 busy_o
);

  localparam int AW     = clog2(FifoDepth);
  localparam int DW     = CntW + OSC_SEL_W;
  localparam int SelLsb = CntW;

  localparam logic [CntW-1:0] CntMax = '1;

  // Zero-extension makes out-of-range
  // selects read a constant 0.
  logic [31:0] osc_pad;
  logic        osc_mux;
  logic        edge_pulse;

  assign osc_pad = 32'(OscIn_i);
  assign osc_mux = osc_pad[OscSel_i];

  osc_edge_sync u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .d_i     (osc_mux),
    .pulse_o (edge_pulse)
  );

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // clear beats count; count saturates
  always_comb begin
    cnt_d = cnt_q;
    if (!Resetn_i) begin
      cnt_d = '0;
    end else if (Count_i && edge_pulse &&
                 cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  logic [DW-1:0] push_data;

  assign push_data[SelLsb +: OSC_SEL_W] = OscSel_i;
  assign push_data[CNT_LSB +: CntW]     = cnt_q;

  logic [DW-1:0] mem_q [FifoDepth];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic [AW:0]   wptr_d;
  logic [AW:0]   rptr_d;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees the slot the push may take.
  assign pop     = !empty && rd.ready;
  assign push_ok = Sample_i && (!full || pop);
  assign drop    = Sample_i && !push_ok;

  assign wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
  assign rptr_d = rptr_q + {{AW{1'b0}}, pop};

  // FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // FIFO storage, written at the tail
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= push_data;
    end
  end

  assign rd.valid = !empty;
  assign rd.data  = mem_q[rptr_q[AW-1:0]];

  logic [DROP_W-1:0] drop_q;
  logic [DROP_W-1:0] drop_d;
  logic              busy_q;
  logic              busy_d;

  // saturating drop count, busy flag
  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != DROP_MAX) begin
      drop_d = drop_q + 1'b1;
    end
    busy_d = Count_i || (wptr_d != rptr_d);
  end

  // status registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_q <= '0;
      busy_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
      busy_q <= busy_d;
    end
  end

  assign drop_cnt_o = drop_q;
  assign busy_o     = busy_q;

endmodule
